// File: rtl/rob_pkg.sv
// Shared sizes and entry/commit record layouts for the reorder buffer.
// The commit packet is the record handed to the writeback/regfile side.
package rob_pkg;

   localparam int ROB_DEPTH      = 16;
   localparam int INST_TAG_WIDTH = 4;
   localparam int TAG_W          = INST_TAG_WIDTH;
   localparam int DATA_W         = 32;
   localparam int REG_W          = 5;

   typedef struct packed {
      logic              busy;
      logic              done;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } rob_entry_t;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } commit_pkt_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order tag allocation, tagged ALU writeback capture,
// in-order single retire per cycle, operand readiness lookup and jump flush.
module rob
   import rob_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              alloc_valid,
   input  logic [REG_W-1:0]  alloc_rd,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              wb_valid,
   input  logic [TAG_W-1:0]  wb_tag,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [TAG_W-1:0]  qry_tag,
   output logic              qry_done,
   output logic [DATA_W-1:0] qry_data,
   output logic              commit_valid,
   output logic [TAG_W-1:0]  commit_tag,
   output logic [REG_W-1:0]  commit_rd,
   output logic [DATA_W-1:0] commit_data,
   output logic [TAG_W:0]    count
);

   localparam logic [TAG_W:0] PTR_ONE = (TAG_W+1)'(1);

   rob_entry_t       r_ent [ROB_DEPTH];
   logic [TAG_W:0]   r_head;
   logic [TAG_W:0]   r_tail;
   commit_pkt_t      r_commit;

   logic             w_full;
   logic             w_alloc;
   logic             w_wb;
   logic             w_commit;
   logic [TAG_W-1:0] w_head_idx;
   logic [TAG_W-1:0] w_tail_idx;
   rob_entry_t       w_head_ent;

   assign w_head_idx = r_head[TAG_W-1:0];
   assign w_tail_idx = r_tail[TAG_W-1:0];
   assign w_head_ent = r_ent[w_head_idx];

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign w_full   = (w_head_idx == w_tail_idx) && (r_head[TAG_W] != r_tail[TAG_W]);
   assign w_alloc  = alloc_valid && !w_full;
   assign w_wb     = wb_valid && r_ent[wb_tag].busy;
   assign w_commit = w_head_ent.busy && w_head_ent.done;

   assign alloc_ready  = !w_full;
   assign alloc_tag    = w_tail_idx;
   assign count        = r_tail - r_head;

   assign commit_valid = r_commit.valid;
   assign commit_tag   = r_commit.tag;
   assign commit_rd    = r_commit.rd;
   assign commit_data  = r_commit.data;

   // A result arriving this cycle is forwarded ahead of the stored copy.
   always_comb begin
      qry_done = r_ent[qry_tag].busy & r_ent[qry_tag].done;
      qry_data = r_ent[qry_tag].data;
      if (wb_valid && (wb_tag == qry_tag) && r_ent[qry_tag].busy) begin
         qry_done = 1'b1;
         qry_data = wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_commit <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            r_ent[i] <= '0;
         end
      end else if (flush) begin
         r_head         <= '0;
         r_tail         <= '0;
         r_commit.valid <= 1'b0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            r_ent[i].busy <= 1'b0;
            r_ent[i].done <= 1'b0;
         end
      end else begin
         if (w_commit) begin
            r_commit.valid     <= 1'b1;
            r_commit.tag       <= w_head_idx;
            r_commit.rd        <= w_head_ent.rd;
            r_commit.data      <= (w_head_ent.rd == '0) ? '0 : w_head_ent.data;
            r_ent[w_head_idx].busy <= 1'b0;
            r_head             <= r_head + PTR_ONE;
         end else begin
            r_commit.valid <= 1'b0;
         end

         if (w_wb) begin
            r_ent[wb_tag].done <= 1'b1;
            r_ent[wb_tag].data <= wb_data;
         end

         // Allocation only ever targets a non-busy slot, so it cannot race wb.
         if (w_alloc) begin
            r_ent[w_tail_idx].busy <= 1'b1;
            r_ent[w_tail_idx].done <= 1'b0;
            r_ent[w_tail_idx].rd   <= alloc_rd;
            r_ent[w_tail_idx].data <= '0;
            r_tail                 <= r_tail + PTR_ONE;
         end
      end
   end

endmodule
